// File: rtl/secure_router_pkg.sv
// ----------------------------------------------------------------------------
// secure_router_pkg
//   Shared definitions for the password-gated router: the FSM state width,
//   the fixed state encodings and a small helper that recognises legal codes.
//   The encodings are fixed because the state register is visible on the
//   router's 'state' output and downstream logic decodes it directly.
// ----------------------------------------------------------------------------
package secure_router_pkg;

    localparam int SR_STATE_W = 3;

    localparam logic [SR_STATE_W-1:0] SR_OFF     = 3'b000;
    localparam logic [SR_STATE_W-1:0] SR_ACTIVE  = 3'b001;
    localparam logic [SR_STATE_W-1:0] SR_GRANT   = 3'b101;
    localparam logic [SR_STATE_W-1:0] SR_DENY    = 3'b111;
    localparam logic [SR_STATE_W-1:0] SR_SAVE    = 3'b110;
    localparam logic [SR_STATE_W-1:0] SR_LOCKOUT = 3'b010;

    // True for the six codes the FSM may legally hold; everything else is
    // treated as corruption and sent back to OFF.
    function automatic logic sr_state_legal(input logic [SR_STATE_W-1:0] s);
        return (s == SR_OFF)   || (s == SR_ACTIVE) || (s == SR_GRANT) ||
               (s == SR_DENY)  || (s == SR_SAVE)   || (s == SR_LOCKOUT);
    endfunction

endpackage

// File: rtl/secure_router_chan_reg.sv
// ----------------------------------------------------------------------------
// chan_reg
//   One output channel of the router: a DW-bit data register loaded on 'we'
//   plus a sticky valid flag that is set by a write and cleared by 'rd'.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous active-high reset (clears data and valid)
//     we    in   write enable, loads din and sets valid
//     din   in   DW-bit data to store
//     rd    in   read strobe, clears valid (data is kept)
//     q     out  stored data word
//     vld   out  data-present flag
// ----------------------------------------------------------------------------
module chan_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] din,
    input  logic          rd,
    output logic [DW-1:0] q,
    output logic          vld
);

    // Data register: only a write changes it, so a read leaves the last
    // word visible to the display side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= din;
        end
    end

    // Valid flag: a write on the same edge as a read wins, so a word that
    // arrives while the consumer is draining the old one is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (we) begin
            vld <= 1'b1;
        end else if (rd) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/secure_router.sv
// ----------------------------------------------------------------------------
// secure_router
//   Password-gated data router. A session opens while 'rq' is high; the
//   correct password confirmed with 'cf' grants write access, after which
//   each confirmed word is steered into one of NCH channel registers chosen
//   by the word's low bits. Consecutive wrong passwords are counted and
//   MAX_TRIES of them lock the router out for LOCK_CYCLES clock cycles.
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     rq        in   request level, low aborts the session (except LOCKOUT)
//     cf        in   confirm strobe, one action per high cycle
//     pd        in   password / data word (DW bits)
//     rd        in   per-channel read strobe, clears that channel's valid
//     dout      out  channel registers, channel i at [i*DW +: DW]
//     valid     out  per-channel sticky data-present flags
//     state     out  current FSM state code
//     fail_cnt  out  consecutive failed password attempts
//     locked    out  high while in LOCKOUT
// ----------------------------------------------------------------------------
module secure_router
    import secure_router_pkg::*;
#(
    parameter int          DW          = 4,
    parameter logic [DW-1:0] PASSWORD  = 4'b1101,
    parameter int          NCH         = 2,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 16,
    localparam int         CW          = $clog2(NCH),
    localparam int         FW          = $clog2(MAX_TRIES + 1),
    localparam int         TW          = $clog2(LOCK_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq,
    input  logic                  cf,
    input  logic [DW-1:0]         pd,
    input  logic [NCH-1:0]        rd,
    output logic [NCH*DW-1:0]     dout,
    output logic [NCH-1:0]        valid,
    output logic [SR_STATE_W-1:0] state,
    output logic [FW-1:0]         fail_cnt,
    output logic                  locked
);

    logic [SR_STATE_W-1:0] state_nx;
    logic [FW-1:0]         fail_nx;
    logic [FW-1:0]         fail_inc;
    logic [TW-1:0]         lock_tmr;
    logic [TW-1:0]         tmr_nx;
    logic                  wr_en;
    logic [CW-1:0]         wr_ch;
    logic [NCH-1:0]        ch_we;

    // In ACTIVE the counter is always below MAX_TRIES (reaching it leaves
    // for LOCKOUT), so the increment cannot overflow FW bits.
    assign fail_inc = fail_cnt + FW'(1);
    assign wr_ch    = pd[CW-1:0];

    // Next-state logic. Dropping rq returns to OFF from any state except
    // LOCKOUT, which ignores the front end entirely until its timer runs out.
    // Illegal codes fall through to OFF.
    always_comb begin
        state_nx = state;
        fail_nx  = fail_cnt;
        tmr_nx   = lock_tmr;
        wr_en    = 1'b0;

        if (!sr_state_legal(state)) begin
            state_nx = SR_OFF;
        end else if (state == SR_LOCKOUT) begin
            if (lock_tmr == TW'(LOCK_CYCLES - 1)) begin
                state_nx = SR_OFF;
                fail_nx  = '0;
                tmr_nx   = '0;
            end else begin
                tmr_nx = lock_tmr + TW'(1);
            end
        end else if (!rq) begin
            state_nx = SR_OFF;
        end else begin
            case (state)
                SR_OFF: begin
                    state_nx = SR_ACTIVE;
                end
                SR_ACTIVE: begin
                    if (cf) begin
                        if (pd == PASSWORD) begin
                            state_nx = SR_GRANT;
                            fail_nx  = '0;
                        end else begin
                            fail_nx = fail_inc;
                            if (fail_inc >= FW'(MAX_TRIES)) begin
                                state_nx = SR_LOCKOUT;
                                tmr_nx   = '0;
                            end else begin
                                state_nx = SR_DENY;
                            end
                        end
                    end
                end
                SR_DENY: begin
                    if (cf) begin
                        state_nx = SR_ACTIVE;
                    end
                end
                SR_GRANT: begin
                    if (cf) begin
                        wr_en    = 1'b1;
                        state_nx = SR_SAVE;
                    end
                end
                SR_SAVE: begin
                    if (cf) begin
                        state_nx = SR_GRANT;
                    end
                end
                default: begin
                    state_nx = SR_OFF;
                end
            endcase
        end
    end

    // Control registers. 'locked' is registered from the next state so it
    // rises and falls on exactly the same edges as the LOCKOUT state code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SR_OFF;
            fail_cnt <= '0;
            lock_tmr <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nx;
            fail_cnt <= fail_nx;
            lock_tmr <= tmr_nx;
            locked   <= (state_nx == SR_LOCKOUT);
        end
    end

    // Channel decoder and per-channel storage.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign ch_we[i] = wr_en && (wr_ch == CW'(i));

        chan_reg #(
            .DW (DW)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .we  (ch_we[i]),
            .din (pd),
            .rd  (rd[i]),
            .q   (dout[i*DW +: DW]),
            .vld (valid[i])
        );
    end

endmodule
